mem_crc_ctrl: RTL and testbench
===============================

MEM_CRC_CTRL -- requirements
Module: mem_crc_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width (2^ADDR_W entries).
REQ-002 Parameter DATA_W, fixed 8; CRC width fixed 8.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  1  requester has a command.
REQ-006 req_ready  output  1  controller can accept a command.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_W  target entry.
REQ-009 req_wdata  input  8  write data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  requester consumes the response.
REQ-012 rsp_rdata  output  8  read data; 0 for writes.
REQ-013 rsp_err  output  1  CRC mismatch on a read; 0 for writes.
REQ-014 mem_we  output  1  storage write strobe.
REQ-015 mem_re  output  1  storage read strobe.
REQ-016 mem_addr  output  ADDR_W  storage address.
REQ-017 mem_wdata  output  16  {data[7:0], crc[7:0]} to storage.
REQ-018 mem_rdata  input  16  {data, crc} from storage; valid the cycle after mem_re (registered flop-bank read).

Function
REQ-019 The FSM SHALL have the states IDLE, READ, CAP, CALC, WRITE, CHECK and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a command is accepted on the cycle where req_valid&&req_ready (cycle 0), latching we, addr and wdata.
REQ-021 Write path: IDLE -> CALC (8 cycles) -> WRITE (1 cycle: mem_we=1, mem_addr=addr, mem_wdata={wdata,crc}) -> RESP.
REQ-022 Read path: IDLE -> READ (1 cycle, mem_re=1) -> CAP (capture mem_rdata) -> CALC (8 cycles, on captured data) -> CHECK (1 cycle) -> RESP.
REQ-023 CRC SHALL be CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed bit-serially MSB first, one bit per CALC cycle.
REQ-024 Write: rsp_valid SHALL rise on cycle 10 after acceptance; read: on cycle 12.
REQ-025 CHECK SHALL set rsp_err = (computed CRC != stored CRC) and rsp_rdata = captured data; rsp_rdata is returned even when rsp_err=1.
REQ-026 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1; the FSM then returns to IDLE on the next edge.
REQ-027 rsp_ready=1 outside RESP SHALL be ignored; req_valid outside IDLE SHALL be ignored without side effects.
REQ-028 mem_we and mem_re SHALL never be 1 together and are each asserted at most one cycle per command.
REQ-029 Back-to-back commands: after the RESP handshake, req_ready SHALL be 1 in the following cycle (one IDLE cycle minimum).

Reset
REQ-030 While rst=1: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, CRC register=0.
REQ-031 A reset asserted mid-command SHALL abort it: no mem_we after rst rises, no response is produced, and the storage is left with whatever was written before reset.

Configuration
REQ-032 With MEM_CRC_ERR_CNT_EN defined: an extra output err_cnt [7:0], reset to 0, SHALL increment on each RESP handshake with rsp_err=1 and saturate at 0xFF.
REQ-033 Without MEM_CRC_ERR_CNT_EN: the err_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 Package mem_access_pkg SHALL hold the CRC8_POLY (0x07) and CRC8_INIT (0x00) constants, the FSM state enum, and DATA_W/CRC_W.
REQ-035 The serial CRC engine SHALL be one sub-module, crc8_serial (inputs: clear, enable, bit_in; output: crc[7:0]), instantiated once.

Verification
REQ-036 Write addr 3, data 0x01 -> mem_we pulses on cycle 9 with mem_wdata=0x0107; rsp_valid on cycle 10, rsp_err=0.
REQ-037 Write 0xFF to addr 5, then read addr 5 -> mem_wdata=0xFFF3; read returns rsp_rdata=0xFF, rsp_err=0.
REQ-038 Read where the model returns mem_rdata=0xFEF3 (bit flip) -> rsp_rdata=0xFE, rsp_err=1; with MEM_CRC_ERR_CNT_EN, err_cnt goes 0 -> 1.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0; a req_valid during RESP is dropped.
REQ-040 Assert rst during CALC of a write -> no mem_we; outputs at reset values; the next read of that address returns the old contents.
REQ-041 256 erroneous reads with MEM_CRC_ERR_CNT_EN -> err_cnt saturates at 0xFF.

Source files
------------

// File: rtl/mem_crc_ctrl_pkg.sv
// Shared constants and FSM state type for the CRC-protected memory controller.
package mem_access_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CRC_W  = 8;

   localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;
   localparam logic [CRC_W-1:0] CRC8_INIT = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_CAP,
      ST_CALC,
      ST_WRITE,
      ST_CHECK,
      ST_RESP
   } state_e;

endpackage

// File: rtl/mem_crc_ctrl_if.sv
// Requester and storage signals of the CRC memory controller.
// slave  : the controller side, master : requester plus storage side.
interface mem_crc_ctrl_if #(
   parameter int unsigned ADDR_W = 4
);

   logic                                                req_valid;
   logic                                                req_ready;
   logic                                                req_we;
   logic [ADDR_W-1:0]                                   req_addr;
   logic [mem_access_pkg::DATA_W-1:0]                   req_wdata;
   logic                                                rsp_valid;
   logic                                                rsp_ready;
   logic [mem_access_pkg::DATA_W-1:0]                   rsp_rdata;
   logic                                                rsp_err;
   logic                                                mem_we;
   logic                                                mem_re;
   logic [ADDR_W-1:0]                                   mem_addr;
   logic [mem_access_pkg::DATA_W+mem_access_pkg::CRC_W-1:0] mem_wdata;
   logic [mem_access_pkg::DATA_W+mem_access_pkg::CRC_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_we, mem_re, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_we, mem_re, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_crc_ctrl_crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00, MSB first), one bit per enabled cycle.
module crc8_serial
   import mem_access_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc
);

   logic [CRC_W-1:0] crc_q;

   // LFSR update: shift left, fold in the polynomial when the outgoing bit differs from the input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_q <= CRC8_INIT;
      end else if (clear) begin
         crc_q <= CRC8_INIT;
      end else if (enable) begin
         crc_q <= {crc_q[CRC_W-2:0], 1'b0} ^ ((crc_q[CRC_W-1] ^ bit_in) ? CRC8_POLY : '0);
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/mem_crc_ctrl.sv
// CRC-protected memory access controller: writes store {data, crc8(data)},
// reads recompute the CRC over the stored data and flag a mismatch.
// Optional feature macro: MEM_CRC_ERR_CNT_EN adds a saturating err_cnt output.
module mem_crc_ctrl
   import mem_access_pkg::*;
#(
   parameter int unsigned ADDR_W = 4
)
(
   input  logic          clk,
   input  logic          rst,
   mem_crc_ctrl_if.slave bus
`ifdef MEM_CRC_ERR_CNT_EN
   ,
   output logic [7:0]    err_cnt
`endif
);

   state_e              state_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   shift_q;
   logic [CRC_W-1:0]    crc_ref_q;
   logic [2:0]          cnt_q;
   logic                req_ready_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                rsp_err_q;
   logic                mem_we_q;
   logic                mem_re_q;

   logic                crc_clear;
   logic                crc_en;
   logic [CRC_W-1:0]    crc;

   assign crc_clear = (state_q == ST_IDLE);
   assign crc_en    = (state_q == ST_CALC);

   crc8_serial u_crc (
      .clk    (clk),
      .rst    (rst),
      .clear  (crc_clear),
      .enable (crc_en),
      .bit_in (shift_q[DATA_W-1]),
      .crc    (crc)
   );

   // Command sequencer with registered handshake and storage strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         shift_q     <= '0;
         crc_ref_q   <= '0;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  we_q        <= bus.req_we;
                  addr_q      <= bus.req_addr;
                  data_q      <= bus.req_wdata;
                  shift_q     <= bus.req_wdata;
                  cnt_q       <= '0;
                  req_ready_q <= 1'b0;
                  if (bus.req_we) begin
                     state_q <= ST_CALC;
                  end else begin
                     state_q  <= ST_READ;
                     mem_re_q <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               mem_re_q <= 1'b0;
               state_q  <= ST_CAP;
            end
            ST_CAP: begin
               data_q    <= bus.mem_rdata[DATA_W+CRC_W-1:CRC_W];
               shift_q   <= bus.mem_rdata[DATA_W+CRC_W-1:CRC_W];
               crc_ref_q <= bus.mem_rdata[CRC_W-1:0];
               cnt_q     <= '0;
               state_q   <= ST_CALC;
            end
            ST_CALC: begin
               shift_q <= {shift_q[DATA_W-2:0], 1'b0};
               cnt_q   <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  if (we_q) begin
                     state_q  <= ST_WRITE;
                     mem_we_q <= 1'b1;
                  end else begin
                     state_q <= ST_CHECK;
                  end
               end
            end
            ST_WRITE: begin
               mem_we_q    <= 1'b0;
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= '0;
               rsp_err_q   <= 1'b0;
               state_q     <= ST_RESP;
            end
            ST_CHECK: begin
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= data_q;
               rsp_err_q   <= (crc != crc_ref_q);
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // The final CRC bit lands on the same edge that enters WRITE, so the
   // write word is formed from live registers gated by the strobe.
   assign bus.mem_wdata = mem_we_q ? {data_q, crc} : '0;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_re    = mem_re_q;
   assign bus.mem_addr  = addr_q;
   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

`ifdef MEM_CRC_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   // Saturating count of CRC errors delivered to the requester
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if ((state_q == ST_RESP) && bus.rsp_ready && rsp_err_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_crc_ctrl.sv
// Directed and randomized bench for mem_crc_ctrl with a flop-bank storage model
// and a high-level reference (CRC by polynomial long division, byte array of contents).
module tb_mem_crc_ctrl;

   logic clk;
   logic rst;
`ifdef MEM_CRC_ERR_CNT_EN
   logic [7:0] err_cnt;
   int         exp_cnt;
`endif

   mem_crc_ctrl_if #(.ADDR_W(4)) bus ();

   mem_crc_ctrl #(.ADDR_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef MEM_CRC_ERR_CNT_EN
      ,
      .err_cnt (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Storage model: registered read, optional single-bit corruption of the data LSB
   logic [15:0] mem_model [16];
   logic        mem_clr;
   logic        flip;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) mem_model[i] <= '0;
      end else begin
         if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
         if (bus.mem_re) bus.mem_rdata <= mem_model[bus.mem_addr] ^ (flip ? 16'h0100 : 16'h0000);
      end
   end

   logic [7:0] ref_data [16];
   int checks;
   int passed;

   function automatic logic [7:0] crc_ref(input logic [7:0] d);
      logic [15:0] r;
      r = {d, 8'h00};
      for (int i = 15; i >= 8; i--)
         if (r[i]) r = r ^ (16'h0107 << (i - 8));
      return r[7:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
      chk({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
      chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
      chk({tag, "_mem_re"},    32'(bus.mem_re),    32'd0);
      chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
      chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
`ifdef MEM_CRC_ERR_CNT_EN
      chk({tag, "_err_cnt"},   32'(err_cnt),       32'd0);
`endif
   endtask

   // One full command: issue, watch strobes, check response, hold, handshake
   task automatic do_cmd(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                         input logic corrupt, input int hold, input logic noisy);
      int cyc, we_cyc, re_cyc, n_we, n_re, n_both;
      logic [15:0] we_data;
      logic [3:0]  we_addr, re_addr;
      logic [7:0]  exp_rd, stored;
      logic        exp_err;
      we_data = '0; we_addr = '0; re_addr = '0;
      chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
      flip = corrupt;
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      cyc = 1; we_cyc = -1; re_cyc = -1; n_we = 0; n_re = 0; n_both = 0;
      while (!bus.rsp_valid && cyc < 40) begin
         if (bus.mem_we) begin n_we++; we_cyc = cyc; we_data = bus.mem_wdata; we_addr = bus.mem_addr; end
         if (bus.mem_re) begin n_re++; re_cyc = cyc; re_addr = bus.mem_addr; end
         if (bus.mem_we && bus.mem_re) n_both++;
         if (noisy) begin
            bus.req_valid = 1'($urandom_range(0, 1)); bus.req_we = 1'b1;
            bus.req_addr = 4'($urandom_range(0, 15)); bus.req_wdata = 8'($urandom);
            bus.rsp_ready = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1; cyc++;
      end
      bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
      flip = 1'b0;
      chk("rsp_latency", 32'(cyc), we ? 32'd10 : 32'd12);
      chk("we_re_overlap", 32'(n_both), 32'd0);
      if (we) begin
         chk("mem_we_count", 32'(n_we), 32'd1);
         chk("mem_re_count", 32'(n_re), 32'd0);
         chk("mem_we_cycle", 32'(we_cyc), 32'd9);
         chk("mem_wdata", 32'(we_data), 32'({wd, crc_ref(wd)}));
         chk("mem_we_addr", 32'(we_addr), 32'(addr));
         ref_data[addr] = wd;
         exp_rd = '0; exp_err = 1'b0;
      end else begin
         chk("mem_re_count", 32'(n_re), 32'd1);
         chk("mem_we_count", 32'(n_we), 32'd0);
         chk("mem_re_cycle", 32'(re_cyc), 32'd1);
         chk("mem_re_addr", 32'(re_addr), 32'(addr));
         stored  = ref_data[addr];
         exp_rd  = corrupt ? (stored ^ 8'h01) : stored;
         exp_err = (crc_ref(exp_rd) != crc_ref(stored));
      end
      chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
      chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      for (int h = 0; h < hold; h++) begin
         bus.req_valid = 1'b1; bus.req_we = 1'b1;
         bus.req_addr = 4'($urandom_range(0, 15)); bus.req_wdata = 8'($urandom);
         @(posedge clk); #1;
         chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("hold_rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
         chk("hold_rsp_err", 32'(bus.rsp_err), 32'(exp_err));
         chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
         chk("hold_mem_we", 32'(bus.mem_we), 32'd0);
      end
      bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("post_req_ready", 32'(bus.req_ready), 32'd1);
      chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
`ifdef MEM_CRC_ERR_CNT_EN
      if (exp_err && exp_cnt < 255) exp_cnt++;
      chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int stray_we;
      logic w;
      logic [3:0] a;
      checks = 0; passed = 0;
`ifdef MEM_CRC_ERR_CNT_EN
      exp_cnt = 0;
`endif
      for (int i = 0; i < 16; i++) ref_data[i] = '0;
      flip = 1'b0; mem_clr = 1'b1;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.rsp_ready = 1'b0; bus.mem_rdata = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("por");
      rst = 1'b0; mem_clr = 1'b0;
      @(posedge clk); #1;

      // Write 0x01 to addr 3 -> word 0x0107
      do_cmd(1'b1, 4'd3, 8'h01, 1'b0, 0, 1'b0);
      chk("crc_0x01", 32'(mem_model[3]), 32'h0107);
      // Write 0xFF to addr 5, read back
      do_cmd(1'b1, 4'd5, 8'hFF, 1'b0, 0, 1'b0);
      chk("crc_0xFF", 32'(mem_model[5]), 32'hFFF3);
      do_cmd(1'b0, 4'd5, 8'h00, 1'b0, 0, 1'b0);
      // Corrupted read 0xFEF3 -> data 0xFE with error
      do_cmd(1'b0, 4'd5, 8'h00, 1'b1, 0, 1'b0);
      // Response held for 5 cycles with a stray request
      do_cmd(1'b0, 4'd3, 8'h00, 1'b0, 5, 1'b0);

      // Reset during CALC of a write aborts it
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd5; bus.req_wdata = 8'h55;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      @(posedge clk); #1;
      chk_reset_vals("rst_held");
      rst = 1'b0;
      stray_we = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (bus.mem_we || bus.rsp_valid) stray_we++;
      end
      chk("abort_no_activity", 32'(stray_we), 32'd0);
      chk("abort_storage", 32'(mem_model[5]), 32'hFFF3);
      do_cmd(1'b0, 4'd5, 8'h00, 1'b0, 0, 1'b0);

      // Randomized traffic with noise on ignored inputs
      for (int n = 0; n < 30; n++) begin
         w = 1'($urandom_range(0, 1));
         a = 4'($urandom_range(0, 15));
         do_cmd(w, a, 8'($urandom), w ? 1'b0 : ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 3)), 1'b1);
      end

`ifdef MEM_CRC_ERR_CNT_EN
      for (int n = 0; n < 256; n++) do_cmd(1'b0, 4'd5, 8'h00, 1'b1, 0, 1'b0);
      chk("err_cnt_saturated", 32'(err_cnt), 32'h0000_00FF);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
